// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB register-memory completer.
// Holds the FSM state enum, bus widths, the default ID word and the byte-lane merge function.
package apb_slv_pkg;

    localparam int APB_DW = 32;
    localparam int APB_SW = 4;

    localparam logic [APB_DW-1:0] ID_VAL_DEF = 32'h4150_4231;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic [APB_DW-1:0] merge_strb(
        input logic [APB_DW-1:0] old_w,
        input logic [APB_DW-1:0] new_w,
        input logic [APB_SW-1:0] strb
    );
        logic [APB_DW-1:0] res;
        res = old_w;
        for (int b = 0; b < APB_SW; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_slv_regmem_array.sv
// DEPTH x 32-bit word storage with asynchronous clear, per-byte write enables
// and a combinational read port.
module apb_slv_regmem_array
    import apb_slv_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              we,
    input  logic [APB_SW-1:0] be,
    input  logic [AW-1:0]     waddr,
    input  logic [APB_DW-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [APB_DW-1:0] rdata
);

    logic [APB_DW-1:0] mem [DEPTH];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= merge_strb(mem[waddr], wdata, be);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slv_regmem.sv
// APB3/APB4 completer: word-addressed register memory with programmable wait
// states and PSLVERR on out-of-range accesses or writes to the read-only ID word.
module apb_slv_regmem
    import apb_slv_pkg::*;
#(
    parameter int                DEPTH    = 16,
    parameter int                WAIT_CYC = 0,
    parameter logic [APB_DW-1:0] ID_VAL   = ID_VAL_DEF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       paddr,
    input  logic [APB_DW-1:0] pwdata,
    input  logic [APB_SW-1:0] pstrb,
    input  logic [2:0]        pprot,
    output logic [APB_DW-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = (WAIT_CYC == 0) ? 1 : $clog2(WAIT_CYC + 1);
    localparam logic [31:0] ADDR_LIM = 32'(DEPTH * 4);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              err_q;
    logic              wr_q;
    logic [APB_DW-1:0] prdata_q;
    logic [AW-1:0]     idx_q;
    logic [APB_DW-1:0] wdata_q;
    logic [APB_SW-1:0] strb_q;

    logic [AW-1:0]     idx_in;
    logic              err_in;
    logic              setup;
    logic              arr_we;
    logic [APB_DW-1:0] arr_rdata;

    // protection bits and the byte offset within a word carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{pprot, paddr[1:0]};

    assign idx_in = paddr[AW+1:2];
    assign err_in = (paddr >= ADDR_LIM) || (pwrite && (idx_in == '0));
    assign setup  = (state_q == IDLE) && psel && !penable;

    assign pready  = (state_q == ACCESS) && (cnt_q == '0);
    assign pslverr = pready && err_q;
    assign prdata  = prdata_q;
    assign arr_we  = pready && psel && wr_q && !err_q;

    // control path: FSM, wait counter, error flag and read-data register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            prdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        state_q <= ACCESS;
                        cnt_q   <= CW'(WAIT_CYC);
                        err_q   <= err_in;
                        wr_q    <= pwrite;
                        if (!pwrite) begin
                            if (err_in)              prdata_q <= '0;
                            else if (idx_in == '0)   prdata_q <= ID_VAL;
                            else                     prdata_q <= arr_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // data path: write payload captured at setup, consumed at completion
    always_ff @(posedge pclk) begin
        if (setup) begin
            idx_q   <= idx_in;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
        end
    end

    apb_slv_regmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (arr_we),
        .be      (strb_q),
        .waddr   (idx_q),
        .wdata   (wdata_q),
        .raddr   (idx_in),
        .rdata   (arr_rdata)
    );

endmodule

// File: tb/tb_apb_slv_regmem.sv
// Bench for apb_slv_regmem: one instance with no wait states and one with three,
// checked against an array-based reference model of the register memory.
module tb_apb_slv_regmem;

    localparam int          DEPTH = 16;
    localparam logic [31:0] IDW   = 32'h4150_4231;
    localparam int          WAITS [2] = '{0, 3};

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel_v;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    int          sel;

    logic        psel0, psel1;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic        rdy, serr;
    logic [31:0] rdat;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd [2];

    always #5 pclk = ~pclk;

    assign psel0 = psel_v && (sel == 0);
    assign psel1 = psel_v && (sel == 1);
    assign rdy   = (sel == 1) ? pready1  : pready0;
    assign serr  = (sel == 1) ? pslverr1 : pslverr0;
    assign rdat  = (sel == 1) ? prdata1  : prdata0;

    apb_slv_regmem #(.DEPTH(DEPTH), .WAIT_CYC(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slv_regmem #(.DEPTH(DEPTH), .WAIT_CYC(3)) u_dut1 (
        .pclk(pclk), .presetn(presetn), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
            last_rd[d] = '0;
        end
    endtask

    // reference: what a transfer should return, and its effect on the memory image
    task automatic model_xfer(input int d, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] st,
                              output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        idx     = int'(a / 4) % DEPTH;
        exp_err = (a >= 32'(DEPTH * 4)) || (wr && idx == 0);
        if (wr) begin
            if (!exp_err)
                for (int b = 0; b < 4; b++)
                    if (st[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
            if (exp_err)        last_rd[d] = '0;
            else if (idx == 0)  last_rd[d] = IDW;
            else                last_rd[d] = mdl[d][idx];
        end
        exp_rd = last_rd[d];
    endtask

    // drives one full APB transfer; expects to start at #1 after a rising edge
    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic err, output int lat);
        bit done;
        sel     = d;
        psel_v  = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        pprot   = 3'($urandom);
        @(posedge pclk); #1;
        penable = 1'b1;
        lat  = 1;
        done = 1'b0;
        rd   = 'x;
        err  = 1'bx;
        while (!done && lat < 40) begin
            lat++;
            if (rdy === 1'b1) begin
                rd   = rdat;
                err  = serr;
                done = 1'b1;
            end else begin
                check("pslverr_while_waiting", {31'b0, serr}, 32'h0);
            end
            @(posedge pclk); #1;
        end
        psel_v  = 1'b0;
        penable = 1'b0;
    endtask

    task automatic do_check(input int d, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        err;
        int          lat;
        xfer(d, wr, a, wd, st, rd, err, lat);
        model_xfer(d, wr, a, wd, st, exp_rd, exp_err);
        check("latency", 32'(lat), 32'(2 + WAITS[d]));
        check("pslverr", {31'b0, err}, {31'b0, exp_err});
        check("prdata", rd, exp_rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          d;

        presetn = 1'b0;
        psel_v  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        pprot   = '0;
        sel     = 0;
        model_clear();

        repeat (2) @(posedge pclk);
        #1;
        check("rst_pready0",  {31'b0, pready0},  32'h0);
        check("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
        check("rst_prdata0",  prdata0,           32'h0);
        check("rst_pready1",  {31'b0, pready1},  32'h0);
        check("rst_prdata1",  prdata1,           32'h0);
        presetn = 1'b1;
        @(posedge pclk); #1;

        // ID word, byte-strobed write, wait-state write
        do_check(0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
        check("id_read", rd, IDW);
        do_check(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'b0101, rd);
        do_check(0, 1'b0, 32'h8, 32'h0, 4'h0, rd);
        check("strb_merge", rd, 32'h00AD_00EF);
        do_check(1, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, rd);
        do_check(1, 1'b0, 32'h4, 32'h0, 4'h0, rd);
        check("wait_rd_0x4", rd, 32'hCAFE_F00D);

        // error responses
        do_check(0, 1'b0, 32'h40, 32'h0, 4'h0, rd);
        do_check(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, rd);
        do_check(0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
        check("id_after_err_wr", rd, IDW);
        do_check(1, 1'b1, 32'h8, 32'h1111_2222, 4'h0, rd);

        // abort a write to 0xC in the second wait cycle
        sel = 1; psel_v = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'hC; pwdata = 32'hA5A5_5A5A; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("abort_w1_pready", {31'b0, rdy}, 32'h0);
        @(posedge pclk); #1;
        check("abort_w2_pready", {31'b0, rdy}, 32'h0);
        psel_v = 1'b0; penable = 1'b0;
        repeat (4) begin
            @(posedge pclk); #1;
            check("abort_after_pready", {31'b0, rdy}, 32'h0);
        end
        do_check(1, 1'b0, 32'hC, 32'h0, 4'h0, rd);
        check("abort_no_commit", rd, 32'h0);

        // psel with penable but no setup phase must be ignored
        sel = 0; psel_v = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8;
        repeat (3) begin
            @(posedge pclk); #1;
            check("no_setup_pready", {31'b0, rdy}, 32'h0);
        end
        psel_v = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        do_check(0, 1'b0, 32'h8, 32'h0, 4'h0, rd);

        // randomized traffic on both instances
        for (int n = 0; n < 60; n++) begin
            d = int'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 79));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            do_check(d, 1'($urandom), a, $urandom, 4'($urandom), rd);
        end

        // asynchronous reset in the middle of an access
        do_check(0, 1'b1, 32'h4, 32'h1234_5678, 4'hF, rd);
        sel = 0; psel_v = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("pre_rst_prdata", prdata0, 32'h1234_5678);
        #1;
        presetn = 1'b0;
        #1;
        check("async_rst_pready",  {31'b0, pready0},  32'h0);
        check("async_rst_pslverr", {31'b0, pslverr0}, 32'h0);
        check("async_rst_prdata",  prdata0,           32'h0);
        model_clear();
        psel_v = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        do_check(0, 1'b0, 32'h4, 32'h0, 4'h0, rd);
        check("rst_cleared_0x4", rd, 32'h0);
        do_check(1, 1'b0, 32'h4, 32'h0, 4'h0, rd);
        check("rst_cleared_0x4_w3", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
